// File: rtl/scan_query_pkg.sv
// rtl/scan_query_pkg.sv - shared states and default sizes for the scan query controller
package scan_query_pkg;

  localparam int SQ_NFF = 5;
  localparam int SQ_NPI = 18;
  localparam int SQ_NPO = 19;
  localparam int SQ_CW  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_RESP
  } sq_state_t;

endpackage

// File: rtl/scan_query_ctrl_if.sv
// rtl/scan_query_ctrl_if.sv - request, core scan and response signals of the scan query controller
interface scan_query_ctrl_if
  import scan_query_pkg::*;
#(
  parameter int NFF = SQ_NFF,
  parameter int NPI = SQ_NPI,
  parameter int NPO = SQ_NPO,
  parameter int CW  = SQ_CW
);

  logic           req_valid;
  logic           req_ready;
  logic [NFF-1:0] req_state;
  logic [NPI-1:0] req_pi;
  logic [CW-1:0]  req_cycles;
  logic           scan_en;
  logic           scan_in;
  logic           scan_out;
  logic           core_clk_en;
  logic [NPI-1:0] core_pi;
  logic [NPO-1:0] core_po;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [NFF-1:0] rsp_state;
  logic [NPO-1:0] rsp_po;
  logic           busy;

  modport master (
    input  req_valid, req_state, req_pi, req_cycles, scan_out, core_po, rsp_ready,
    output req_ready, scan_en, scan_in, core_clk_en, core_pi, rsp_valid, rsp_state, rsp_po, busy
  );

  modport slave (
    output req_valid, req_state, req_pi, req_cycles, scan_out, core_po, rsp_ready,
    input  req_ready, scan_en, scan_in, core_clk_en, core_pi, rsp_valid, rsp_state, rsp_po, busy
  );

endinterface

// File: rtl/sq_down_counter.sv
// rtl/sq_down_counter.sv - loadable down counter, tc flags the last cycle of a phase
module sq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Phases load length-1, so tc marks the final cycle and no count ever wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/scan_query_ctrl.sv
// rtl/scan_query_ctrl.sv - scans a state into a core, runs it, captures outputs and scans the state back out
module scan_query_ctrl
  import scan_query_pkg::*;
#(
  parameter int NFF = SQ_NFF,
  parameter int NPI = SQ_NPI,
  parameter int NPO = SQ_NPO,
  parameter int CW  = SQ_CW
) (
  input  logic              clk,
  input  logic              rst,
  scan_query_ctrl_if.master bus
);

  localparam int CNTW = (CW > $clog2(NFF)) ? CW : $clog2(NFF);

  sq_state_t      st, nxt;
  logic [NFF-1:0] load_sr;
  logic [NFF-1:0] rsp_state_q;
  logic [NPI-1:0] pi_q;
  logic [CW-1:0]  cycles_q;
  logic [NPO-1:0] rsp_po_q;
  logic           cnt_load, cnt_dec, cnt_tc;
  logic [CNTW-1:0] cnt_val;

  sq_down_counter #(.W(CNTW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt      = st;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (st)
      ST_IDLE: if (bus.req_valid) begin
        nxt      = ST_LOAD;
        cnt_load = 1'b1;
        cnt_val  = CNTW'(NFF - 1);
      end
      ST_LOAD: if (!cnt_tc) begin
        cnt_dec = 1'b1;
      end else if (cycles_q == '0) begin
        nxt = ST_CAPTURE;
      end else begin
        nxt      = ST_RUN;
        cnt_load = 1'b1;
        cnt_val  = CNTW'(cycles_q) - CNTW'(1);
      end
      ST_RUN: if (cnt_tc) nxt = ST_CAPTURE;
              else        cnt_dec = 1'b1;
      ST_CAPTURE: begin
        nxt      = ST_UNLOAD;
        cnt_load = 1'b1;
        cnt_val  = CNTW'(NFF - 1);
      end
      ST_UNLOAD: if (cnt_tc) nxt = ST_RESP;
                 else        cnt_dec = 1'b1;
      ST_RESP: if (bus.rsp_ready) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // load_sr feeds the chain MSB first; rsp_state fills from bit 0 so the MSB lands back on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sr     <= '0;
      pi_q        <= '0;
      cycles_q    <= '0;
      rsp_po_q    <= '0;
      rsp_state_q <= '0;
    end else begin
      if (st == ST_IDLE && bus.req_valid) begin
        load_sr  <= bus.req_state;
        pi_q     <= bus.req_pi;
        cycles_q <= bus.req_cycles;
      end
      if (st == ST_LOAD)    load_sr     <= {load_sr[NFF-2:0], 1'b0};
      if (st == ST_CAPTURE) rsp_po_q    <= bus.core_po;
      if (st == ST_UNLOAD)  rsp_state_q <= {rsp_state_q[NFF-2:0], bus.scan_out};
    end
  end

  assign bus.req_ready   = (st == ST_IDLE) && !rst;
  assign bus.scan_en     = (st == ST_LOAD) || (st == ST_UNLOAD);
  assign bus.core_clk_en = (st == ST_LOAD) || (st == ST_RUN) || (st == ST_UNLOAD);
  assign bus.scan_in     = (st == ST_LOAD) ? load_sr[NFF-1] : 1'b0;
  assign bus.core_pi     = (st == ST_LOAD || st == ST_RUN || st == ST_CAPTURE) ? pi_q : '0;
  assign bus.rsp_valid   = (st == ST_RESP);
  assign bus.rsp_state   = rsp_state_q;
  assign bus.rsp_po      = rsp_po_q;
  assign bus.busy        = (st != ST_IDLE);

endmodule

// File: doc/scan_query_ctrl.md
SCAN_QUERY_CTRL -- requirements
Module: scan_query_ctrl

Interface
REQ-001 Parameter NFF, default 5, scan-chain length (core flip-flop count).
REQ-002 Parameter NPI, default 18, core primary-input width.
REQ-003 Parameter NPO, default 19, core primary-output width.
REQ-004 Parameter CW, default 8, run-cycle count width.
REQ-005 CK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  query request.
REQ-008 req_ready  output  1  controller accepts a request.
REQ-009 req_state  input  NFF  state vector to scan into the core.
REQ-010 req_pi  input  NPI  primary inputs applied during RUN.
REQ-011 req_cycles  input  CW  number of functional clocks, 0 legal.
REQ-012 scan_en  output  1  core scan-mode select.
REQ-013 scan_in  output  1  serial data into the core chain.
REQ-014 scan_out  input  1  serial data from the core chain.
REQ-015 core_clk_en  output  1  core flip-flop enable, shift or functional.
REQ-016 core_pi  output  NPI  primary inputs driven to the core.
REQ-017 core_po  input  NPO  core primary outputs.
REQ-018 rsp_valid  output  1  response available.
REQ-019 rsp_ready  input  1  response consumer ready.
REQ-020 rsp_state  output  NFF  unloaded core state.
REQ-021 rsp_po  output  NPO  captured primary outputs.
REQ-022 busy  output  1  high in every state except IDLE.

Function
REQ-023 FSM states SHALL be IDLE, LOAD, RUN, CAPTURE, UNLOAD, RESP.
REQ-024 req_ready SHALL equal (state==IDLE and not RST); acceptance on req_valid & req_ready registers req_state, req_pi, req_cycles and enters LOAD.
REQ-025 LOAD SHALL last exactly NFF cycles with scan_en=1, core_clk_en=1, scan_in driving the registered state MSB first.
REQ-026 After LOAD, RUN SHALL last exactly req_cycles cycles with scan_en=0, core_clk_en=1; req_cycles=0 SHALL skip RUN directly to CAPTURE.
REQ-027 core_pi SHALL present the registered req_pi from LOAD through CAPTURE and all-zero in IDLE, UNLOAD, RESP.
REQ-028 CAPTURE SHALL last one cycle with core_clk_en=0 and register core_po into rsp_po at its closing edge.
REQ-029 UNLOAD SHALL last NFF cycles, scan_en=1, core_clk_en=1, scan_in=0, rsp_state shifting left with scan_out entering at bit 0 each edge.
REQ-030 RESP SHALL hold rsp_valid=1 and rsp_state/rsp_po stable until rsp_valid & rsp_ready, then return to IDLE.
REQ-031 rsp_valid SHALL first assert in cycle 2*NFF+req_cycles+2 after the acceptance edge (cycle 1 = first LOAD cycle).
REQ-032 core_clk_en and scan_en SHALL be 0 in IDLE, CAPTURE and RESP.
REQ-033 A request presented while busy SHALL NOT be accepted and SHALL not disturb the query in flight.
REQ-034 Loading then immediately unloading a pure shift chain SHALL return rsp_state equal to req_state.
REQ-035 req_cycles=2^CW-1 SHALL run exactly 255 cycles (CW=8) without counter wrap.

Reset
REQ-036 RST SHALL immediately force IDLE, scan_en=0, scan_in=0, core_clk_en=0, core_pi=0, rsp_valid=0, busy=0, rsp_state=0, rsp_po=0.
REQ-037 RST asserted mid-LOAD/RUN/UNLOAD SHALL abort the query with no response; req_ready SHALL assert on the first edge after RST deasserts.

Structure
REQ-038 Package scan_query_pkg SHALL hold the state enumeration and default NFF/NPI/NPO/CW constants.
REQ-039 One sub-module, sq_down_counter (loadable, terminal-count flag), SHALL time LOAD, RUN and UNLOAD.

Verification
REQ-040 Loopback: shift-register core model, req_state=5'b10110, req_cycles=0 -> rsp_state=5'b10110, rsp_valid at cycle 12.
REQ-041 Run timing: req_cycles=3 -> exactly 3 cycles with core_clk_en=1 and scan_en=0, rsp_valid at cycle 15.
REQ-042 Capture: core_po forced 19'h5A5A5 during CAPTURE, changed after -> rsp_po=19'h5A5A5.
REQ-043 Backpressure: rsp_ready low 4 cycles in RESP -> outputs stable, req_ready low, one transfer when rsp_ready rises.
REQ-044 Reset mid-RUN (cycle 7, req_cycles=10) -> all outputs at reset values, no rsp_valid, new query after release completes normally.
REQ-045 Max count: req_cycles=8'hFF -> 255 RUN cycles, rsp_valid at cycle 267.
